// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared bus constants, arbitration mode and address-region helper
package mem_bus_arbiter_pkg;
    localparam logic [1:0] IO_REGION  = 2'b11;
    localparam int         IO_SEL_W   = 3;
    localparam int         BUS_DATA_W = 8;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    function automatic logic is_io_region(input logic [1:0] region);
        return region == IO_REGION;
    endfunction
endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant of the first request found scanning upward (with wrap) from a start index
module rr_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  arb_mode_e     mode,
    output logic [N-1:0]  gnt
);
    int start;
    int j;

    // scan offsets from high to low so the smallest offset from the start index wins
    always_comb begin
        start = (mode == ARB_RR) ? int'(ptr) : 0;
        j = 0;
        gnt = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = start + k;
            if (j >= N) j = j - N;
            if (req[j]) gnt = N'(1) << j;
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: N-master byte-bus arbiter with burst locking, RAM/IO decode and read-data return
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int RR_MODE        = 1,
    parameter int LOCK_MAX       = 8
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              rdy_in,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_wr,
    input  logic [NUM_MASTERS-1:0]            m_lock,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*BUS_DATA_W-1:0] m_dout,
    output logic [NUM_MASTERS-1:0]            m_gnt,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    output logic [BUS_DATA_W-1:0]             m_rdata,
    output logic                              ram_en,
    output logic                              ram_wr,
    output logic [RAM_ADDR_WIDTH-1:0]         ram_a,
    output logic [BUS_DATA_W-1:0]             ram_dout,
    input  logic [BUS_DATA_W-1:0]             ram_din,
    output logic                              io_en,
    output logic                              io_wr,
    output logic [IO_SEL_W-1:0]               io_sel,
    output logic [BUS_DATA_W-1:0]             io_dout,
    input  logic [BUS_DATA_W-1:0]             io_din,
    input  logic                              io_full
);
    localparam int N  = NUM_MASTERS;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = BUS_DATA_W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam arb_mode_e MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

    logic [N-1:0]  is_io;
    logic [N-1:0]  elig;
    logic [N-1:0]  cand;
    logic [N-1:0]  arb_gnt;
    logic [IW-1:0] gidx;
    logic          gnt_any;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_dout;
    int            run;
    logic          unused_addr;

    logic [IW-1:0] ptr_q, ptr_d;
    logic          lock_vld_q, lock_vld_d;
    logic [IW-1:0] lock_own_q, lock_own_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          excl_vld_q, excl_vld_d;
    logic [IW-1:0] excl_own_q, excl_own_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [IW-1:0] rsp_master_q, rsp_master_d;
    logic          rsp_is_io_q, rsp_is_io_d;

    assign unused_addr = ^m_addr;

    // per-master region decode; IO writes are held back while the IO buffer is full
    always_comb begin
        is_io = '0;
        elig = '0;
        for (int i = 0; i < N; i++) begin
            is_io[i] = is_io_region(m_addr[i*AW+RAM_ADDR_WIDTH-1 +: 2]);
            elig[i] = m_req[i] & ~(is_io[i] & m_wr[i] & io_full);
        end
    end

    // a live lock leaves only its owner in the race; a force-released owner sits out one round
    assign cand = lock_vld_q ? (elig & (N'(1) << lock_own_q)) :
                  excl_vld_q ? (elig & ~(N'(1) << excl_own_q)) : elig;

    rr_arbiter #(.N(N), .IW(IW)) u_arb (
        .req  (cand),
        .ptr  (ptr_q),
        .mode (MODE),
        .gnt  (arb_gnt)
    );

    assign m_gnt = (rdy_in & ~rst_in) ? arb_gnt : '0;

    // steer the granted master onto the RAM or IO port; an idle bus drives all zeros
    always_comb begin
        gidx = '0;
        for (int i = 0; i < N; i++) if (m_gnt[i]) gidx = IW'(i);
        gnt_any = |m_gnt;
        g_addr = gnt_any ? m_addr[gidx*AW +: AW] : '0;
        g_dout = gnt_any ? m_dout[gidx*DW +: DW] : '0;
        ram_en = gnt_any & ~is_io[gidx];
        io_en = gnt_any & is_io[gidx];
        ram_wr = ram_en & m_wr[gidx];
        io_wr = io_en & m_wr[gidx];
        ram_a = g_addr[RAM_ADDR_WIDTH-1:0];
        io_sel = g_addr[IO_SEL_W-1:0];
        ram_dout = g_dout;
        io_dout = g_dout;
    end

    // next state: rr pointer, lock owner and run length, one-round exclusion, read response
    always_comb begin
        ptr_d = ptr_q;
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        lock_cnt_d = lock_cnt_q;
        excl_vld_d = excl_vld_q;
        excl_own_d = excl_own_q;
        run = 0;
        rsp_valid_d = gnt_any & ~m_wr[gidx];
        rsp_master_d = gidx;
        rsp_is_io_d = is_io[gidx];
        if (rdy_in) begin
            excl_vld_d = 1'b0;
            if (gnt_any) begin
                run = lock_vld_q ? int'(lock_cnt_q) + 1 : 1;
                if (!lock_vld_q) ptr_d = (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
                lock_vld_d = m_lock[gidx] && (run < LOCK_MAX);
                lock_own_d = gidx;
                lock_cnt_d = lock_vld_d ? CW'(run) : '0;
                if (m_lock[gidx] && run >= LOCK_MAX) begin
                    excl_vld_d = 1'b1;
                    excl_own_d = gidx;
                end
            end
        end
    end

    // state registers; reset drops any burst and any read still in flight
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr_q <= '0;
            lock_vld_q <= 1'b0;
            lock_own_q <= '0;
            lock_cnt_q <= '0;
            excl_vld_q <= 1'b0;
            excl_own_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_master_q <= '0;
            rsp_is_io_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            lock_cnt_q <= lock_cnt_d;
            excl_vld_q <= excl_vld_d;
            excl_own_q <= excl_own_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_master_q <= rsp_master_d;
            rsp_is_io_q <= rsp_is_io_d;
        end
    end

    assign m_rvalid = rsp_valid_q ? (N'(1) << rsp_master_q) : '0;
    assign m_rdata = rsp_valid_q ? (rsp_is_io_q ? io_din : ram_din) : '0;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table, directed burst/reset sequences and a random run against a rule-level model
module tb_mem_bus_arbiter;
    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int RAW = 17;
    localparam int LM  = 8;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            rdy_in;
    logic [N-1:0]    m_req, m_wr, m_lock;
    logic [N*AW-1:0] m_addr;
    logic [N*8-1:0]  m_dout;
    logic [N-1:0]    m_gnt, m_rvalid;
    logic [7:0]      m_rdata;
    logic            ram_en, ram_wr, io_en, io_wr, io_full;
    logic [RAW-1:0]  ram_a;
    logic [7:0]      ram_dout, ram_din, io_dout, io_din;
    logic [2:0]      io_sel;

    mem_bus_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RAW), .RR_MODE(1), .LOCK_MAX(LM)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .m_req(m_req), .m_wr(m_wr), .m_lock(m_lock), .m_addr(m_addr), .m_dout(m_dout),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din),
        .io_en(io_en), .io_wr(io_wr), .io_sel(io_sel), .io_dout(io_dout), .io_din(io_din),
        .io_full(io_full)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int passed = 0;

    // reference state, kept as plain integers: next search start, burst owner and length, benched master, read in flight
    int ptr, lk_own, lk_cnt, excl, rv_m;
    bit rv_io;

    typedef struct {
        logic [2:0] req;
        logic [2:0] wr;
        logic [2:0] lock;
        logic       full;
        logic       rdy;
        logic [2:0] gnt;
        logic       ram_en;
        logic       io_en;
        logic [2:0] rvalid;
        logic [7:0] rdata;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] addr_of(input int i);
        return m_addr[i*AW +: AW];
    endfunction

    function automatic bit is_io(input logic [31:0] a);
        return ((a >> (RAW - 1)) & 32'h3) == 32'h3;
    endfunction

    function automatic bit elig(input int i);
        return m_req[i] && !(is_io(addr_of(i)) && m_wr[i] && io_full);
    endfunction

    function automatic int pick();
        if (!rdy_in) return -1;
        if (lk_own >= 0) return elig(lk_own) ? lk_own : -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (j != excl && elig(j)) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        ptr = 0;
        lk_own = -1;
        lk_cnt = 0;
        excl = -1;
        rv_m = -1;
        rv_io = 0;
    endtask

    task automatic model_step(input int g);
        int len;
        rv_m = (g >= 0 && !m_wr[g]) ? g : -1;
        rv_io = (g >= 0) && is_io(addr_of(g));
        if (rdy_in) begin
            excl = -1;
            if (g >= 0) begin
                len = (lk_own >= 0) ? lk_cnt + 1 : 1;
                if (lk_own < 0) ptr = (g + 1) % N;
                if (m_lock[g] && len < LM) begin
                    lk_own = g;
                    lk_cnt = len;
                end else begin
                    if (m_lock[g]) excl = g;
                    lk_own = -1;
                    lk_cnt = 0;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        int g;
        logic [31:0] a;
        bit io, wr;
        logic [7:0] d;
        g = pick();
        a = (g >= 0) ? addr_of(g) : 32'h0;
        io = (g >= 0) && is_io(a);
        wr = (g >= 0) && m_wr[g];
        d = (g >= 0) ? 8'((m_dout >> (8 * g)) & 24'hff) : 8'h0;
        chk({tag, "/gnt"}, 64'(m_gnt), (g >= 0) ? (64'(1) << g) : 64'h0);
        chk({tag, "/ram_en"}, 64'(ram_en), 64'((g >= 0) && !io));
        chk({tag, "/ram_wr"}, 64'(ram_wr), 64'((g >= 0) && !io && wr));
        chk({tag, "/io_en"}, 64'(io_en), 64'(io));
        chk({tag, "/io_wr"}, 64'(io_wr), 64'(io && wr));
        chk({tag, "/ram_a"}, 64'(ram_a), 64'(a % (32'h1 << RAW)));
        chk({tag, "/io_sel"}, 64'(io_sel), 64'(a % 8));
        chk({tag, "/ram_dout"}, 64'(ram_dout), 64'(d));
        chk({tag, "/io_dout"}, 64'(io_dout), 64'(d));
        chk({tag, "/rvalid"}, 64'(m_rvalid), (rv_m >= 0) ? (64'(1) << rv_m) : 64'h0);
        chk({tag, "/rdata"}, 64'(m_rdata), (rv_m < 0) ? 64'h0 : rv_io ? 64'(io_din) : 64'(ram_din));
    endtask

    // entered mid-cycle with inputs settled; leaves 1 time unit after the next rising edge
    task automatic cycle(input string tag);
        int g;
        check_model(tag);
        g = pick();
        @(posedge clk_in);
        model_step(g);
        #1;
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] wr, input logic [2:0] lock,
                         input logic full, input logic rdy);
        m_req = req;
        m_wr = wr;
        m_lock = lock;
        io_full = full;
        rdy_in = rdy;
    endtask

    initial begin
        tbl[0]  = '{3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 3'b000, 8'h00};
        tbl[1]  = '{3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 3'b001, 8'h11};
        tbl[2]  = '{3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, 3'b010, 8'h5A};
        tbl[3]  = '{3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 3'b100, 8'h11};
        tbl[4]  = '{3'b110, 3'b010, 3'b000, 1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 3'b001, 8'h11};
        tbl[5]  = '{3'b110, 3'b010, 3'b000, 1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 3'b100, 8'h11};
        tbl[6]  = '{3'b010, 3'b010, 3'b000, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 3'b100, 8'h11};
        tbl[7]  = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 8'h00};
        tbl[8]  = '{3'b001, 3'b000, 3'b000, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 3'b000, 8'h00};
        tbl[9]  = '{3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b001, 8'h11};
        tbl[10] = '{3'b001, 3'b000, 3'b000, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 3'b000, 8'h00};
        tbl[11] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b001, 8'h11};

        rst_in = 1'b1;
        drive(3'b111, 3'b000, 3'b000, 1'b0, 1'b1);
        m_addr = {32'h0000_0040, 32'h0003_0000, 32'h0000_0010};
        m_dout = 24'hA2A1A0;
        ram_din = 8'h11;
        io_din = 8'h5A;
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset/gnt", 64'(m_gnt), 64'h0);
        chk("reset/ram_en", 64'(ram_en), 64'h0);
        chk("reset/io_en", 64'(io_en), 64'h0);
        chk("reset/wr", 64'({ram_wr, io_wr}), 64'h0);
        chk("reset/rvalid", 64'(m_rvalid), 64'h0);
        chk("reset/rdata", 64'(m_rdata), 64'h0);
        rst_in = 1'b0;
        model_reset();

        for (int r = 0; r < 12; r++) begin
            drive(tbl[r].req, tbl[r].wr, tbl[r].lock, tbl[r].full, tbl[r].rdy);
            #3;
            chk($sformatf("tbl%0d/gnt", r), 64'(m_gnt), 64'(tbl[r].gnt));
            chk($sformatf("tbl%0d/ram_en", r), 64'(ram_en), 64'(tbl[r].ram_en));
            chk($sformatf("tbl%0d/io_en", r), 64'(io_en), 64'(tbl[r].io_en));
            chk($sformatf("tbl%0d/rvalid", r), 64'(m_rvalid), 64'(tbl[r].rvalid));
            chk($sformatf("tbl%0d/rdata", r), 64'(m_rdata), 64'(tbl[r].rdata));
            cycle($sformatf("tbl%0d", r));
        end

        drive(3'b100, 3'b000, 3'b100, 1'b0, 1'b1);
        #3;
        chk("lock1/gnt", 64'(m_gnt), 64'h4);
        cycle("lock1");
        for (int c = 2; c <= LM; c++) begin
            drive(3'b101, 3'b000, 3'b100, 1'b0, 1'b1);
            #3;
            chk($sformatf("lock%0d/gnt", c), 64'(m_gnt), 64'h4);
            cycle($sformatf("lock%0d", c));
        end
        #3;
        chk("lock_release/gnt", 64'(m_gnt), 64'h1);
        cycle("lock_release");
        drive(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        #3;
        cycle("lock_idle");

        drive(3'b010, 3'b010, 3'b010, 1'b0, 1'b1);
        #3;
        chk("stall1/gnt", 64'(m_gnt), 64'h2);
        chk("stall1/io", 64'({io_en, io_wr, io_sel}), 64'h18);
        cycle("stall1");
        drive(3'b011, 3'b010, 3'b010, 1'b1, 1'b1);
        #3;
        chk("stall2/gnt", 64'(m_gnt), 64'h0);
        cycle("stall2");
        drive(3'b011, 3'b010, 3'b010, 1'b0, 1'b1);
        #3;
        chk("stall3/gnt", 64'(m_gnt), 64'h2);
        cycle("stall3");
        drive(3'b011, 3'b010, 3'b000, 1'b0, 1'b1);
        #3;
        chk("stall4/gnt", 64'(m_gnt), 64'h2);
        cycle("stall4");
        #3;
        chk("stall5/gnt", 64'(m_gnt), 64'h1);
        cycle("stall5");

        drive(3'b010, 3'b000, 3'b000, 1'b0, 1'b1);
        m_addr[AW +: AW] = 32'h0000_0100;
        #2;
        chk("rst_mid/gnt_before", 64'(m_gnt), 64'h2);
        chk("rst_mid/ram_a_before", 64'(ram_a), 64'h100);
        rst_in = 1'b1;
        #1;
        chk("rst_mid/gnt", 64'(m_gnt), 64'h0);
        chk("rst_mid/bus", 64'({ram_en, io_en, ram_wr, io_wr, ram_a}), 64'h0);
        chk("rst_mid/rvalid", 64'(m_rvalid), 64'h0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        m_req = 3'b000;
        model_reset();
        #1;
        chk("rst_mid/no_rvalid_after", 64'(m_rvalid), 64'h0);
        #1;
        cycle("post_reset");

        for (int t = 0; t < 400; t++) begin
            drive(3'($urandom), 3'($urandom), 3'($urandom) & 3'($urandom), 1'($urandom),
                  $urandom_range(0, 7) != 0);
            m_addr = {$urandom, $urandom, $urandom};
            m_dout = 24'($urandom);
            ram_din = 8'($urandom);
            io_din = 8'($urandom);
            #3;
            cycle($sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
